// File: rtl/bounce_gen_pkg.sv
// rtl/bounce_gen_pkg.sv - shared types, LFSR constants and step function for bounce_gen
package bounce_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE,
        DONE
    } state_t;

    // One Galois step: shift right, fold taps in when the bit shifted out is 1
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// rtl/bounce_gen_lfsr16.sv - 16-bit Galois LFSR that advances only on request
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    // Hold the value between phase loads so glitch widths are repeatable from SEED
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - switch-bounce generator driving an emulated mechanical switch
module bounce_gen
    import bounce_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             level,
    input  logic [3:0]       bounces,
    input  logic [CNT_W-1:0] max_glitch,
    input  logic [CNT_W-1:0] settle,
    output logic             sw,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    state_t             state;
    logic [LFSR_W-1:0]  lfsr_q;
    logic               lfsr_step;
    logic [CNT_W:0]     phase_cnt;
    logic [4:0]         toggle_cnt;
    logic               level_r;
    logic [3:0]         bounces_r;
    logic [CNT_W-1:0]   glitch_mask_r;
    logic [CNT_W-1:0]   settle_r;

    logic               accept;
    logic               phase_last;
    logic [4:0]         toggle_target;
    logic [CNT_W:0]     width_first;
    logic [CNT_W:0]     width_next;
    logic [CNT_W:0]     settle_first;
    logic [CNT_W:0]     settle_next;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    // Phase lengths are kept as d (not d-1) in CNT_W+1 bits so a full mask cannot overflow
    always_comb begin
        accept        = start && (state == IDLE || state == DONE);
        phase_last    = (phase_cnt == ONE);
        toggle_target = {bounces_r, 1'b0};
        width_first   = {1'b0, lfsr_q[CNT_W-1:0] & max_glitch} + ONE;
        width_next    = {1'b0, lfsr_q[CNT_W-1:0] & glitch_mask_r} + ONE;
        settle_first  = {1'b0, settle} + ONE;
        settle_next   = {1'b0, settle_r} + ONE;
        lfsr_step     = (accept && (level != sw) && (bounces != 4'd0)) ||
                        (state == BOUNCE && phase_last && toggle_cnt != toggle_target);
    end

    // Sequencer: accept request, walk the glitch phases, settle, then pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sw            <= INIT_LEVEL;
            busy          <= 1'b0;
            done          <= 1'b0;
            phase_cnt     <= '0;
            toggle_cnt    <= '0;
            level_r       <= 1'b0;
            bounces_r     <= '0;
            glitch_mask_r <= '0;
            settle_r      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        level_r       <= level;
                        bounces_r     <= bounces;
                        glitch_mask_r <= max_glitch;
                        settle_r      <= settle;
                        busy          <= 1'b1;
                        if (level != sw) begin
                            sw <= level;
                            if (bounces != 4'd0) begin
                                state      <= BOUNCE;
                                phase_cnt  <= width_first;
                                toggle_cnt <= 5'd1;
                            end else begin
                                state     <= SETTLE;
                                phase_cnt <= settle_first;
                            end
                        end else begin
                            state     <= SETTLE;
                            phase_cnt <= settle_first;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                BOUNCE: begin
                    if (phase_last) begin
                        if (toggle_cnt == toggle_target) begin
                            sw        <= level_r;
                            state     <= SETTLE;
                            phase_cnt <= settle_next;
                        end else begin
                            sw         <= ~sw;
                            toggle_cnt <= toggle_cnt + 5'd1;
                            phase_cnt  <= width_next;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - ONE;
                    end
                end
                SETTLE: begin
                    if (phase_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_gen.sv
// tb/tb_bounce_gen.sv - randomized self-checking bench for bounce_gen
module tb_bounce_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        level;
    logic [3:0]  bounces;
    logic [15:0] max_glitch;
    logic [15:0] settle;
    logic        sw;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic sw;
        logic busy;
        logic done;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_sw;
    logic [15:0] m_lfsr;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cyc = 0;

    bounce_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .level      (level),
        .bounces    (bounces),
        .max_glitch (max_glitch),
        .settle     (settle),
        .sw         (sw),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic logic [15:0] model_lfsr_adv(input logic [15:0] x);
        logic [15:0] h;
        h = x / 2;
        return (x % 2 == 1) ? (h ^ 16'hB400) : h;
    endfunction

    // Expand one accepted request into its full per-cycle output trace
    task automatic model_accept();
        logic cur;
        int   d;
        cur = m_sw;
        if (level != cur) begin
            for (int i = 1; i <= 2 * int'(bounces); i++) begin
                d = 1 + int'(m_lfsr & max_glitch);
                m_lfsr = model_lfsr_adv(m_lfsr);
                for (int k = 0; k < d; k++)
                    exp_q.push_back('{sw: (i % 2 == 1) ? level : ~level, busy: 1'b1, done: 1'b0});
            end
        end
        for (int k = 0; k <= int'(settle); k++)
            exp_q.push_back('{sw: level, busy: 1'b1, done: 1'b0});
        exp_q.push_back('{sw: level, busy: 1'b0, done: 1'b1});
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_sw   = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic tick();
        exp_t e;
        if (start && exp_q.size() == 0) begin
            model_accept();
            cyc = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{sw: m_sw, busy: 1'b0, done: 1'b0};
        m_sw = e.sw;
        check("sw", {31'd0, sw}, {31'd0, e.sw});
        check("busy", {31'd0, busy}, {31'd0, e.busy});
        check("done", {31'd0, done}, {31'd0, e.done});
        if (done) done_cyc = cyc;
    endtask

    task automatic run_idle(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("timeout", 32'd1, 32'd0);
    endtask

    task automatic req(input logic lv, input logic [3:0] b, input logic [15:0] mg, input logic [15:0] st);
        level = lv; bounces = b; max_glitch = mg; settle = st;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; level = 1'b0;
        bounces = '0; max_glitch = '0; settle = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sw", {31'd0, sw}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // B=0 settle=3 from reset
        req(1'b1, 4'd0, 16'd0, 16'd3);
        run_idle(100);
        check("t1_done_cyc", done_cyc, 32'd5);

        // B=2, zero glitch mask: one-cycle glitches
        req(1'b0, 4'd2, 16'd0, 16'd0);
        run_idle(100);
        check("t2_done_cyc", done_cyc, 32'd6);

        // level equals sw: settle only
        req(1'b0, 4'd5, 16'd7, 16'd2);
        run_idle(100);
        check("t3_done_cyc", done_cyc, 32'd4);

        // start pulsed mid-sequence is ignored
        req(1'b1, 4'd3, 16'd7, 16'd10);
        tick();
        level = 1'b0; bounces = 4'd9; settle = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        run_idle(200);
        check("t4_final_sw", {31'd0, sw}, 32'd1);

        // start held high: back-to-back sequences
        level = 1'b0; bounces = 4'd1; max_glitch = 16'd1; settle = 16'd1; start = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        start = 1'b0;
        run_idle(200);

        // reset mid-BOUNCE, then rerun from reseeded LFSR
        req(1'b1, 4'd3, 16'd7, 16'd10);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("amid_sw", {31'd0, sw}, 32'd0);
        check("amid_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req(1'b1, 4'd3, 16'd7, 16'd10);
        check("reseed_w1a", {31'd0, sw}, 32'd1);
        tick();
        check("reseed_w1b", {31'd0, sw}, 32'd1);
        tick();
        check("reseed_w1end", {31'd0, sw}, 32'd0);
        run_idle(300);
        check("t6_final_sw", {31'd0, sw}, 32'd1);

        // randomized traffic with parameters changing every cycle
        for (int i = 0; i < 5000; i++) begin
            level   = 1'($urandom);
            bounces = 4'($urandom % 16);
            case ($urandom % 4)
                0: max_glitch = 16'd0;
                1: max_glitch = 16'd3;
                2: max_glitch = 16'd15;
                default: max_glitch = 16'($urandom % 64);
            endcase
            settle = 16'($urandom % 8);
            start  = ((i / 250) % 3 == 2) ? 1'b1 : ($urandom % 6 == 0);
            tick();
        end
        start = 1'b0;
        run_idle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Switch-bounce generator: the driving end of the mechanical-switch input that the debouncing FSM consumes. On a start command it moves its `sw` output to a requested level through a programmable number of glitches with pseudo-random widths, then holds the level for a settle interval. It drives the debouncer's `sw` input directly, for on-board self-test and for repeatable bounce stimulus in simulation.

## Interface
- `CNT_W`, 16: width of the glitch and settle counters; legal range 1..16.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `INIT_LEVEL`, 1'b0: value of `sw` out of reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request pulse or level; sampled only in IDLE or DONE.
- `level`  in  1  target level; latched on accept.
- `bounces`  in  4  number of glitch pairs B, 0..15; latched on accept.
- `max_glitch`  in  CNT_W  glitch-width mask; latched on accept.
- `settle`  in  CNT_W  extra hold cycles on the final level; latched on accept.
- `sw`  out  1  emulated switch output (registered).
- `busy`  out  1  high while a sequence runs.
- `done`  out  1  one-cycle pulse at the end of a sequence.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - BOUNCE: `busy`=1.
  - SETTLE: `busy`=1.
  - DONE: `done`=1, `busy`=0, one cycle, then IDLE.
- Accept: `start`=1 in IDLE or DONE latches `level`, `bounces`, `max_glitch` and `settle`. In BOUNCE or SETTLE, `start` is ignored (no queueing).
- Accept when `level` ≠ `sw`:
  - Enter BOUNCE.
  - `sw` toggles 2B+1 times in total and ends at `level`.
  - Toggle 1 goes to `level`, toggle 2 goes back, and so on.
- Accept when `level` = `sw`: go directly to SETTLE; `sw` never toggles.
- Phase width rules:
  - Each of the first 2B phases holds `sw` for `d` = 1 + (`lfsr[CNT_W-1:0]` & `max_glitch`) cycles, computed from the LFSR value current when the phase is loaded.
  - The LFSR advances one step at each phase load.
  - Range of `d` is 1..`max_glitch`+1. No overflow: the count is held in CNT_W+1 bits.
  - The final phase (toggle 2B+1, or the no-toggle case) is SETTLE and lasts `settle`+1 cycles.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Shift right; if the old bit 0 is 1, XOR with 16'hB400.
  - Never advances outside phase loads.
- Reset:
  - State IDLE, `sw`=INIT_LEVEL, `busy`=0, `done`=0, LFSR=SEED, counters 0.
  - Reset mid-sequence aborts immediately; `sw` returns to INIT_LEVEL.

## Timing
- Cycle 0: `start` sampled high.
- Cycle 1: `sw` shows toggle 1 (`level` ≠ `sw` case), `busy`=1.
- Phases are back to back: each toggle is visible on the cycle immediately after the previous phase's last cycle.
- SETTLE occupies `settle`+1 cycles. `done`=1 on the next cycle, with `busy`=0 in that same cycle.
- Minimum sequence (B=0, `settle`=0): `sw` changes in cycle 1, `done` in cycle 2.
- Total busy cycles = sum(d1..d2B) + `settle` + 1.
- `start` held high through DONE starts the next sequence: the new cycle 1 directly follows the DONE cycle.
- `sw`, `busy` and `done` are all registered. There is no combinational path from any input to any output.

## Structure
- Package `bounce_pkg`:
  - state enum (IDLE, BOUNCE, SETTLE, DONE);
  - `LFSR_TAPS` = 16'hB400;
  - `LFSR_W` = 16.
- Sub-module `lfsr16`:
  - ports `clk`, `reset`, `step`, `q[15:0]`;
  - parameter `SEED`.
- Top level holds:
  - FSM;
  - latched request;
  - phase down-counter (CNT_W+1 bits);
  - toggle counter (5 bits, counting to 2B).

## Test plan
- B=0, `settle`=3, `level`=1 from reset → `sw` rises in cycle 1, `busy` is high in cycles 1–4, `done` in cycle 5.
- B=2, `max_glitch`=0, `settle`=0, `level`=1 → `sw` = 1,0,1,0,1 in cycles 1–5, one cycle each; `done` in cycle 6.
- B=3, `max_glitch`=7, `settle`=10 → every glitch width is in 1..8. Widths must match a bit-accurate LFSR model from SEED=ACE1 (first width 2, since 16'hACE1&7=1). `sw` ends at 1.
- `level`=0 while `sw`=0, `settle`=2 → no `sw` toggle, `busy` for 3 cycles, then `done`. The LFSR does not advance.
- `start` pulsed while `busy` → ignored; the running sequence completes unchanged. `start` held high → back-to-back sequences with no IDLE gap.
- `reset` asserted mid-BOUNCE with `sw`=1 → `sw`=0, `busy`=0 asynchronously. After release, a new sequence reproduces the first-run widths (LFSR reseeded).
